// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, requests words from imem and
// queues them in a 2-entry buffer for decode, with redirect/flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    typedef enum logic {
        FETCH,
        FLUSH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        outst_q, outst_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ins_q [2];
    logic [31:0] ins_d [2];
    logic [31:0] pcb_q [2];
    logic [31:0] pcb_d [2];

    logic        pop;
    logic        req_raw;
    logic [1:0]  cnt_pop;
    logic [31:0] tgt;

    assign instr_valid = (cnt_q != 2'd0);
    assign instr       = instr_valid ? ins_q[0] : NOP_INSTR;
    assign instr_pc    = instr_valid ? pcb_q[0] : 32'h0;
    assign pop         = instr_valid & instr_ready;
    assign cnt_pop     = cnt_q - {1'b0, pop};
    assign tgt         = redirect_pc & 32'hFFFF_FFFC;

    // A request is only raised when a slot is free by the time data lands.
    assign req_raw   = (state_q == FLUSH) | outst_q | (cnt_q < DEPTH) | pop;
    assign imem_req  = req_raw & ~rst;
    assign imem_addr = (state_q == FLUSH) ? addr_q : pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        outst_d = outst_q;
        cnt_d   = cnt_q;
        ins_d   = ins_q;
        pcb_d   = pcb_q;
        if (pop) begin
            ins_d[0] = ins_q[1];
            pcb_d[0] = pcb_q[1];
        end
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    cnt_d   = 2'd0;
                    pc_d    = tgt;
                    outst_d = 1'b0;
                    if (imem_req && !imem_ack) begin
                        state_d = FLUSH;
                        addr_d  = pc_q;
                        outst_d = 1'b1;
                    end
                end else begin
                    outst_d = imem_req & ~imem_ack;
                    cnt_d   = cnt_pop;
                    if (imem_req && imem_ack) begin
                        ins_d[cnt_pop[0]] = imem_rdata;
                        pcb_d[cnt_pop[0]] = pc_q;
                        cnt_d = cnt_pop + 2'd1;
                        pc_d  = pc_q + 32'd4;
                    end
                end
            end
            FLUSH: begin
                cnt_d = 2'd0;
                if (redirect) pc_d = tgt;
                if (imem_ack) begin
                    state_d = FETCH;
                    outst_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            outst_q <= 1'b0;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                ins_q[i] <= NOP_INSTR;
                pcb_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            ins_q   <= ins_d;
            pcb_q   <= pcb_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency
// instruction memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int n_chk;
    int n_fail;
    int lat;
    int wcnt;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h0045_0693;
            32'h4:   mem_word = 32'h0010_0713;
            32'h8:   mem_word = 32'h00b7_6463;
            default: mem_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // ack arrives once req has been held for lat extra cycles
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        #1;
    endtask

    logic [31:0] exp_ins [3];

    initial begin
        n_chk = 0;
        n_fail = 0;
        wcnt = 0;
        lat = 0;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        exp_ins[0] = 32'h0045_0693;
        exp_ins[1] = 32'h0010_0713;
        exp_ins[2] = 32'h00b7_6463;

        // reset state, then first request
        nxt();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", instr_pc, 32'h0);
        nxt();
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("c1_req", {31'b0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", {31'b0, instr_valid}, 32'd0);

        // streaming at one instruction per cycle
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("str_valid", {31'b0, instr_valid}, 32'd1);
            check("str_pc", instr_pc, 32'(i * 4));
            check("str_instr", instr, exp_ins[i]);
        end

        // back-pressure fills the buffer and stops fetching
        do_reset();
        nxt();
        repeat (3) begin
            nxt();
            check("bp_req", {31'b0, imem_req}, 32'd0);
            check("bp_head", instr_pc, 32'h0);
        end
        nxt();
        instr_ready = 1'b1;
        #1;
        check("bp_rel_req", {31'b0, imem_req}, 32'd1);
        check("bp_rel_addr", imem_addr, 32'h8);
        check("bp_pc0", instr_pc, 32'h0);
        check("bp_in0", instr, exp_ins[0]);
        nxt();
        check("bp_pc4", instr_pc, 32'h4);
        check("bp_in4", instr, exp_ins[1]);
        nxt();
        check("bp_pc8", instr_pc, 32'h8);
        check("bp_in8", instr, exp_ins[2]);

        // redirect with ack in the same cycle
        nxt();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("rd_ack", {31'b0, imem_ack}, 32'd1);
        nxt();
        redirect = 1'b0;
        #1;
        check("rd_valid", {31'b0, instr_valid}, 32'd0);
        check("rd_addr", imem_addr, 32'h40);
        nxt();
        check("rd_pc", instr_pc, 32'h40);
        check("rd_instr", instr, 32'hC0DE_0040);

        // redirect while a slow request is in flight
        lat = 2;
        do_reset();
        instr_ready = 1'b1;
        #1;
        check("fl_c1_ack", {31'b0, imem_ack}, 32'd0);
        nxt();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        nxt();
        redirect = 1'b0;
        #1;
        check("fl_hold_req", {31'b0, imem_req}, 32'd1);
        check("fl_hold_addr", imem_addr, 32'h0);
        check("fl_ack", {31'b0, imem_ack}, 32'd1);
        check("fl_valid3", {31'b0, instr_valid}, 32'd0);
        nxt();
        check("fl_new_addr", imem_addr, 32'h40);
        check("fl_valid4", {31'b0, instr_valid}, 32'd0);
        nxt();
        check("fl_valid5", {31'b0, instr_valid}, 32'd0);
        nxt();
        check("fl_valid6", {31'b0, instr_valid}, 32'd0);
        nxt();
        check("fl_pc", instr_pc, 32'h40);
        check("fl_instr", instr, 32'hC0DE_0040);

        // second redirect during flush, misaligned target
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h80;
        #1;
        nxt();
        redirect_pc = 32'h42;
        #1;
        check("f2_addr", imem_addr, 32'h0);
        nxt();
        redirect = 1'b0;
        #1;
        check("f2_ack", {31'b0, imem_ack}, 32'd1);
        nxt();
        check("f2_new_addr", imem_addr, 32'h40);
        check("f2_valid", {31'b0, instr_valid}, 32'd0);

        // reset while flushing abandons the stale request
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        nxt();
        redirect = 1'b0;
        rst = 1'b1;
        #1;
        check("fr_req", {31'b0, imem_req}, 32'd0);
        nxt();
        rst = 1'b0;
        #1;
        check("fr_req2", {31'b0, imem_req}, 32'd1);
        check("fr_addr", imem_addr, 32'h0);
        check("fr_valid", {31'b0, instr_valid}, 32'd0);
        nxt();
        nxt();
        nxt();
        check("fr_pc", instr_pc, 32'h0);
        check("fr_instr", instr, exp_ins[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
